// File: rtl/mux_pipe.sv
// Registered N:1 word selector behind a two-entry skid buffer (main + skid).
// Out-of-range selectors produce a zero word flagged by out_err and counted in err_cnt.
module mux_pipe #(
   parameter  int N    = 8,
   parameter  int W    = 8,
   localparam int SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*W-1:0]  data,
   input  logic [SELW-1:0] sel,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out,
   output logic            out_err,
   output logic [7:0]      err_cnt
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t         state_reg, state_next;
   logic [W-1:0]   m_data_reg, m_data_next;
   logic           m_err_reg, m_err_next;
   logic [W-1:0]   s_data_reg, s_data_next;
   logic           s_err_reg, s_err_next;
   logic [7:0]     err_cnt_reg, err_cnt_next;

   logic [W-1:0]   words [N];
   logic [W-1:0]   res_data;
   logic           res_err;
   logic           accept;
   logic           drain;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_words
         assign words[gi] = data[gi*W +: W];
      end
   endgenerate

   // Match against every legal index so no out-of-range array access exists.
   always_comb begin
      res_data = '0;
      res_err  = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (sel == SELW'(k)) begin
            res_data = words[k];
            res_err  = 1'b0;
         end
      end
   end

   assign in_ready  = !rst && (state_reg != TWO);
   assign out_valid = (state_reg != EMPTY);
   assign out       = out_valid ? m_data_reg : '0;
   assign out_err   = out_valid & m_err_reg;
   assign err_cnt   = err_cnt_reg;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   always_comb begin
      state_next   = state_reg;
      m_data_next  = m_data_reg;
      m_err_next   = m_err_reg;
      s_data_next  = s_data_reg;
      s_err_next   = s_err_reg;
      err_cnt_next = err_cnt_reg;

      if (accept && res_err && (err_cnt_reg != 8'hFF))
         err_cnt_next = err_cnt_reg + 8'd1;

      case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next  = ONE;
               m_data_next = res_data;
               m_err_next  = res_err;
            end
         end
         ONE: begin
            if (accept && drain) begin
               m_data_next = res_data;
               m_err_next  = res_err;
            end else if (accept) begin
               state_next  = TWO;
               s_data_next = res_data;
               s_err_next  = res_err;
            end else if (drain) begin
               state_next  = EMPTY;
            end
         end
         TWO: begin
            if (drain) begin
               state_next  = ONE;
               m_data_next = s_data_reg;
               m_err_next  = s_err_reg;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= EMPTY;
         m_data_reg  <= '0;
         m_err_reg   <= 1'b0;
         s_data_reg  <= '0;
         s_err_reg   <= 1'b0;
         err_cnt_reg <= 8'd0;
      end else begin
         state_reg   <= state_next;
         m_data_reg  <= m_data_next;
         m_err_reg   <= m_err_next;
         s_data_reg  <= s_data_next;
         s_err_reg   <= s_err_next;
         err_cnt_reg <= err_cnt_next;
      end
   end

endmodule

// File: tb/tb_mux_pipe.sv
// Directed bench for mux_pipe: N=6 instance for the main scenarios,
// N=8 instance to confirm a power-of-two selector never flags an error.
module tb_mux_pipe;

   localparam int N  = 6;
   localparam int W  = 8;
   localparam int SW = $clog2(N);
   localparam int N8 = 8;
   localparam int SW8 = $clog2(N8);

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, in_ready;
   logic [N*W-1:0] data;
   logic [SW-1:0]  sel;
   logic           out_valid, out_ready;
   logic [W-1:0]   out;
   logic           out_err;
   logic [7:0]     err_cnt;

   logic            p_in_valid, p_in_ready;
   logic [N8*W-1:0] p_data;
   logic [SW8-1:0]  p_sel;
   logic            p_out_valid, p_out_ready;
   logic [W-1:0]    p_out;
   logic            p_out_err;
   logic [7:0]      p_err_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mux_pipe #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .data(data), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_err(out_err), .err_cnt(err_cnt)
   );

   mux_pipe #(.N(N8), .W(W)) dut8 (
      .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
      .data(p_data), .sel(p_sel), .out_valid(p_out_valid), .out_ready(p_out_ready),
      .out(p_out), .out_err(p_out_err), .err_cnt(p_err_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0;
      p_in_valid = 1'b0; p_out_ready = 1'b0; p_sel = '0;
      tick(); tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", out); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      rst = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
      $display("reset done");
   endtask

   task automatic test_single();
      out_ready = 1'b1; sel = 3'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out !== 8'h13) begin errors++; $display("FAIL single_out got=%h exp=13", out); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", out_err); end
      $display("single sel=3 out=%h", out);
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", out_valid); end
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL single_out_idle got=%h exp=00", out); end
   endtask

   task automatic test_stream();
      logic [7:0] exp;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
         sel = SW'(i);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
         tick();
         exp = 8'h10 + 8'(i);
         checks++;
         if (out_valid !== 1'b1 || out !== exp) begin
            errors++; $display("FAIL stream_out[%0d] got=%b/%h exp=1/%h", i, out_valid, out, exp);
         end
         $display("stream sel=%0d out=%h", i, out);
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0; in_valid = 1'b1; sel = 3'd1;
      tick();
      sel = 3'd2;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_two got=%b exp=0", in_ready); end
      checks++; if (out !== 8'h11) begin errors++; $display("FAIL bp_hold0 got=%h exp=11", out); end
      tick();
      checks++; if (out !== 8'h11 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold1 got=%b/%h exp=1/11", out_valid, out); end
      out_ready = 1'b1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_comb_ready got=%b exp=0", in_ready); end
      $display("backpressure drain out=%h", out);
      tick();
      checks++; if (out !== 8'h12 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second got=%b/%h exp=1/12", out_valid, out); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
      $display("backpressure drain out=%h", out);
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_out_of_range();
      out_ready = 1'b1; in_valid = 1'b1; sel = 3'd7;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out !== 8'h00 || out_err !== 1'b1) begin
            errors++; $display("FAIL oor_result[%0d] got=%b/%h/%b exp=1/00/1", i, out_valid, out, out_err);
         end
         $display("oor sel=7 out=%h err=%b", out, out_err);
      end
      checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL oor_cnt3 got=%0d exp=3", err_cnt); end
      for (int i = 3; i < 255; i++) tick();
      checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL oor_cnt255 got=%0d exp=255", err_cnt); end
      for (int i = 255; i < 300; i++) tick();
      in_valid = 1'b0;
      tick();
      checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL oor_sat got=%0d exp=255", err_cnt); end
      sel = 3'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out !== 8'h15 || out_err !== 1'b0) begin errors++; $display("FAIL oor_recover got=%h/%b exp=15/0", out, out_err); end
      tick();
   endtask

   task automatic test_reset_in_two();
      out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0;
      tick(); tick();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst2_setup got=%b exp=0", in_ready); end
      rst = 1'b1; out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst2_valid got=%b exp=0", out_valid); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst2_err_cnt got=%0d exp=0", err_cnt); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst2_ready got=%b exp=0", in_ready); end
      rst = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst2_release got=%b/%b exp=1/0", in_ready, out_valid); end
      $display("reset in TWO done");
   endtask

   task automatic test_pow2();
      logic [7:0] exp;
      p_out_ready = 1'b1; p_in_valid = 1'b1;
      for (int i = 0; i < N8; i++) begin
         p_sel = SW8'(i);
         tick();
         exp = 8'h20 + 8'(i);
         checks++;
         if (p_out !== exp || p_out_err !== 1'b0) begin
            errors++; $display("FAIL pow2_out[%0d] got=%h/%b exp=%h/0", i, p_out, p_out_err, exp);
         end
         $display("pow2 sel=%0d out=%h", i, p_out);
      end
      p_in_valid = 1'b0;
      tick();
      checks++; if (p_err_cnt !== 8'd0) begin errors++; $display("FAIL pow2_err_cnt got=%0d exp=0", p_err_cnt); end
   endtask

   initial begin
      for (int k = 0; k < N; k++) data[k*W +: W] = 8'h10 + 8'(k);
      for (int k = 0; k < N8; k++) p_data[k*W +: W] = 8'h20 + 8'(k);
      test_reset();
      test_single();
      test_stream();
      test_back_to_back();
      test_out_of_range();
      test_reset_in_two();
      test_pow2();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 Parameter N, default 8, number of input words (N >= 2).
REQ-002 Parameter W, default 8, width of each input word and of the output (W >= 1).
REQ-003 Derived constant SELW = $clog2(N), the selector width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  producer offers data/sel this cycle.
REQ-007 in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready.
REQ-008 data  input  N*W  packed input words; word k = data[k*W +: W].
REQ-009 sel  input  SELW  index of the word to select.
REQ-010 out_valid  output  1  out/out_err hold a valid result.
REQ-011 out_ready  input  1  consumer accepts; a drain occurs when out_valid && out_ready.
REQ-012 out  output  W  selected word.
REQ-013 out_err  output  1  the result came from an out-of-range sel.
REQ-014 err_cnt  output  8  saturating count of accepted out-of-range selections.

Function
REQ-015 The block SHALL be a two-entry skid buffer: a main register M (drives out/out_err/out_valid) and a skid register S.
REQ-016 The state machine SHALL have states EMPTY (M, S invalid), ONE (M valid), and TWO (M, S valid).
REQ-017 On accept, the stored result SHALL be word data[sel] with err=0 when sel < N; otherwise 0 with err=1.
REQ-018 Out-of-range handling SHALL be a normal result, never a simulation stop; when N is a power of two, err SHALL never be 1.
REQ-019 in_ready SHALL be 1 exactly when state != TWO and rst=0, and SHALL have no combinational path from out_ready.
REQ-020 EMPTY + accept -> ONE; M loads the result. Latency from accept edge to out_valid=1 is 1 cycle.
REQ-021 ONE + accept + drain -> ONE; M loads the new result (full throughput, one word per cycle).
REQ-022 ONE + accept, no drain -> TWO; S loads the result and M holds.
REQ-023 ONE + drain, no accept -> EMPTY.
REQ-024 TWO + drain -> ONE; M loads from S. In TWO no accept is possible.
REQ-025 In all other cases the state, M, and S SHALL hold.
REQ-026 While out_valid=1 and out_ready=0, out and out_err SHALL be stable.
REQ-027 Results SHALL drain in the order accepted; none SHALL be lost or duplicated.
REQ-028 err_cnt SHALL increment by 1 on each accept with sel >= N and saturate at 255. Draining SHALL NOT affect it.
REQ-029 out_valid SHALL equal (state != EMPTY); out SHALL be 0 when out_valid=0.

Reset
REQ-030 While rst=1 at a clock edge: state <- EMPTY, M and S <- 0, and out_valid, out, out_err, and err_cnt <- 0.
REQ-031 Reset SHALL take priority over any simultaneous accept or drain; in-flight results are discarded.
REQ-032 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Verification (N=6, W=8, SELW=3 unless stated)
REQ-033 data words k = 8'h10+k, sel=3, out_ready=1, in_valid one cycle -> next cycle out_valid=1, out=8'h13, out_err=0; EMPTY the cycle after.
REQ-034 Continuous in_valid, out_ready=1, sel=0..5 -> out=8'h10..8'h15 on consecutive cycles, in_ready constantly 1.
REQ-035 out_ready=0, two accepts (sel=1, then 2) -> in_ready=0 after the second, out=8'h11 stable; raise out_ready -> 8'h11 then 8'h12 delivered.
REQ-036 sel=7 accepted 3 times -> out=0, out_err=1 each time, err_cnt=3; with 300 such accepts -> err_cnt=255.
REQ-037 State TWO, assert rst with out_ready=1 -> next cycle out_valid=0, err_cnt=0, in_ready=0; after deassert in_ready=1.
REQ-038 N=8, SELW=3, all sel values -> out_err never 1, err_cnt stays 0.
